// File: rtl/gf163_mul_ctrl.sv
// Control and register side of the 32-digit systolic GF(2^163) multiplier.
// Feeds b MSB-digit first into the combinational array and accumulates its result.
module gf163_mul_ctrl #(
  parameter int M = 163,
  parameter int D = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a_in,
  input  logic [M-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] p_out,
  output logic [M-1:0] arr_a,
  output logic [D-1:0] arr_b_digit,
  output logic [M-1:0] arr_t_fb,
  input  logic [M-1:0] arr_t_res,
  output logic         busy,
  output logic [2:0]   step_cnt,
  output logic [1:0]   dbg_state
);

  localparam int STEPS = (M + D - 1) / D;
  localparam int PADW  = STEPS * D;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; the source holds its data stable until then, and valid never waits on ready.

  logic [1:0]      state_q, state_d;
  logic [M-1:0]    a_q, a_d;
  logic [PADW-1:0] b_pad_q, b_pad_d;
  logic [M-1:0]    acc_q, acc_d;
  logic [2:0]      step_q, step_d;

  logic run;

  assign run         = (state_q == S_RUN);
  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign p_out       = out_valid ? acc_q : '0;
  assign arr_a       = a_q;
  assign arr_b_digit = run ? b_pad_q[PADW-1 -: D] : '0;
  assign arr_t_fb    = run ? acc_q : '0;
  assign step_cnt    = step_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_pad_d = b_pad_q;
    acc_d   = acc_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_pad_d = {{(PADW-M){1'b0}}, b_in};
          acc_d   = '0;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = arr_t_res;
        b_pad_d = {b_pad_q[PADW-D-1:0], {D{1'b0}}};
        if (step_q == 3'(STEPS - 1)) begin
          state_d = S_DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_DONE: begin
        // a and acc are left alone so the product stays on p_out until taken.
        if (out_ready) begin
          state_d = S_IDLE;
          step_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_pad_q <= '0;
      acc_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_pad_q <= b_pad_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_gf163_mul_ctrl.sv
// Bench for gf163_mul_ctrl: behavioural digit-array model attached to the array
// ports, directed product table, bit-serial reference for random operands.
module tb_gf163_mul_ctrl;

  localparam int M = 163;
  localparam int D = 32;
  localparam logic [M-1:0] F_LOW = 163'hC9;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a_in;
  logic [M-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] p_out;
  logic [M-1:0] arr_a;
  logic [D-1:0] arr_b_digit;
  logic [M-1:0] arr_t_fb;
  logic [M-1:0] arr_t_res;
  logic         busy;
  logic [2:0]   step_cnt;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  gf163_mul_ctrl #(.M(M), .D(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .p_out(p_out),
    .arr_a(arr_a), .arr_b_digit(arr_b_digit), .arr_t_fb(arr_t_fb),
    .arr_t_res(arr_t_res), .busy(busy), .step_cnt(step_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0] mulx(input logic [M-1:0] t);
    return {t[M-2:0], 1'b0} ^ (t[M-1] ? F_LOW : '0);
  endfunction

  // One pass through the 32 rows: Horner step, digit MSB first.
  function automatic logic [M-1:0] array_step(input logic [M-1:0] fb, input logic [M-1:0] a,
                                              input logic [D-1:0] dig);
    logic [M-1:0] t;
    t = fb;
    for (int i = D - 1; i >= 0; i--) begin
      t = mulx(t);
      if (dig[i]) t = t ^ a;
    end
    return t;
  endfunction

  // Independent reference: LSB-first shift-and-add over b.
  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ aa;
      aa = mulx(aa);
    end
    return p;
  endfunction

  always_comb arr_t_res = array_step(arr_t_fb, arr_a, arr_b_digit);

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [M-1:0] rand_m();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[M-1:0];
  endfunction

  // Runs one product; stall = cycles out_ready is held low in DONE,
  // hold_valid keeps in_valid high with a changing a_in through RUN/DONE.
  task automatic do_op(input logic [M-1:0] a, input logic [M-1:0] b, input int stall,
                       input bit hold_valid, output logic [M-1:0] p, output int lat);
    logic [191:0] bp;
    logic [M-1:0] held;
    @(negedge clk);
    check("in_ready_idle", {191'b0, in_ready}, 192'd1);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = (stall == 0);
    bp        = {29'b0, b};
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (hold_valid) begin
        a_in = rand_m();
        check("in_ready_busy", {191'b0, in_ready}, 192'd0);
      end else begin
        in_valid = 1'b0;
      end
      if (!out_valid && lat <= 6) begin
        check("arr_b_digit", {160'b0, arr_b_digit}, {160'b0, bp[191:160]});
        check("step_cnt_run", {189'b0, step_cnt}, 192'(lat - 1));
        bp = bp << D;
      end
    end while (!out_valid && lat < 40);
    check("latency", 192'(lat), 192'd7);
    check("digit_done_zero", {160'b0, arr_b_digit}, 192'd0);
    check("fb_done_zero", {29'b0, arr_t_fb}, 192'd0);
    held = p_out;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("valid_stall", {191'b0, out_valid}, 192'd1);
      check("p_stable", {29'b0, p_out}, {29'b0, held});
    end
    p = held;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("valid_drop", {191'b0, out_valid}, 192'd0);
    check("in_ready_back", {191'b0, in_ready}, 192'd1);
  endtask

  typedef struct {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] p;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [M-1:0] p, a, b, a0, one;
    int lat, k;
    one = 163'd1;
    vecs[0] = '{one,        one,        one};
    vecs[1] = '{one << 162, 163'h2,     163'hC9};
    vecs[2] = '{163'h3,     163'h3,     163'h5};
    vecs[3] = '{one << 100, one << 62,  one << 162};
    vecs[4] = '{one << 81,  one << 82,  163'hC9};
    vecs[5] = '{one << 162, 163'h4,     163'h192};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {191'b0, in_ready}, 192'd1);
    check("rst_out_valid", {191'b0, out_valid}, 192'd0);
    check("rst_busy", {191'b0, busy}, 192'd0);
    check("rst_step", {189'b0, step_cnt}, 192'd0);
    check("rst_state", {190'b0, dbg_state}, 192'd0);
    check("rst_p_out", {29'b0, p_out}, 192'd0);
    check("rst_arr_a", {29'b0, arr_a}, 192'd0);
    check("rst_digit", {160'b0, arr_b_digit}, 192'd0);
    check("rst_fb", {29'b0, arr_t_fb}, 192'd0);

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, i % 3, 1'b0, p, lat);
      check("vec_product", {29'b0, p}, {29'b0, vecs[i].p});
    end

    // All-ones b: first digit carries only bits 162:160.
    do_op(one, {M{1'b1}}, 0, 1'b0, p, lat);
    check("ones_product", {29'b0, p}, {29'b0, {M{1'b1}}});

    // in_valid held through RUN/DONE with a_in changing every cycle.
    a0 = rand_m();
    b  = rand_m();
    do_op(a0, b, 3, 1'b1, p, lat);
    check("held_valid_product", {29'b0, p}, {29'b0, ref_mul(a0, b)});

    // Reset while RUN sits at step 3.
    @(negedge clk);
    in_valid = 1'b1; a_in = rand_m(); b_in = rand_m(); out_ready = 1'b1;
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      k++;
    end while (step_cnt != 3'd3 && k < 20);
    check("reach_step3", {191'b0, (step_cnt == 3'd3)}, 192'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_state", {190'b0, dbg_state}, 192'd0);
    check("midrst_busy", {191'b0, busy}, 192'd0);
    check("midrst_step", {189'b0, step_cnt}, 192'd0);
    check("midrst_arr_a", {29'b0, arr_a}, 192'd0);
    check("midrst_in_ready", {191'b0, in_ready}, 192'd1);
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) k++;
    end
    check("midrst_no_valid", 192'(k), 192'd0);
    out_ready = 1'b0;
    do_op(one, one, 0, 1'b0, p, lat);
    check("post_rst_product", {29'b0, p}, 192'd1);

    for (int i = 0; i < 1000; i++) begin
      a = rand_m();
      b = rand_m();
      do_op(a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'b0, p, lat);
      check("rand_product", {29'b0, p}, {29'b0, ref_mul(a, b)});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
